retire_trace_fifo: RTL and testbench
====================================

# retire_trace_fifo

Synthesizable event-capture buffer between the multicycle RV32I core and its consumer (simulation checker or debug drain port). Captures each architectural register write and memory write on a single clock. Queues the events in a FIFO and presents them one at a time on a valid/ready output port. Overflow is reported instead of stalling the core.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 4
- `DROP_W`, 16, width of the saturating dropped-event counter
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `register_write_en`  in  1  core writes the register file this cycle
- `rd_address`  in  5  destination register
- `register_file_write`  in  32  register write data
- `memory_write_en`  in  1  core writes memory this cycle
- `memory_write_address`  in  32  store address
- `memory_write`  in  32  store data
- `pc_out`  in  32  PC of the instruction generating the event (used only with `TRACE_PC_EN`)
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head entry
- `out_kind`  out  2  2'b01 register write, 2'b10 memory write
- `out_tag`  out  32  `{27'b0, rd}` for register writes; address for memory writes
- `out_data`  out  32  written value
- `out_pc`  out  32  present only with `TRACE_PC_EN`
- `level`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky; set when any event is dropped
- `drop_count`  out  DROP_W  dropped events, saturating at all-ones

## Operation
- Register event qualifies when `register_write_en && rd_address != 0`; x0 writes are never captured.
- Memory event qualifies when `memory_write_en`.
- Per cycle, 0, 1 or 2 pushes. With two qualifying events, the register event is ordered before the memory event.
- Free slots for this cycle = `DEPTH - level + pop`, where `pop = out_valid && out_ready`. A pop frees its slot for same-cycle pushes.
- Two events with one free slot: register event stored, memory event dropped.
- Zero free slots: all qualifying events dropped.
- Each dropped event increments `drop_count` by 1 (by 2 if both dropped), saturating. Any drop sets `overflow`.
- `overflow` and `drop_count` clear only on reset.
- Storage is a circular buffer with read and write pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
- `level` updates as `level + pushes - pop`.
- `out_*` reflect the head entry whenever `out_valid`. Contents are don't-care otherwise but must be stable (no X after reset).
- The block never back-pressures the core.

## Timing
- Reset asserted (low), asynchronously: pointers, `level`, `out_valid`, `overflow` and `drop_count` go to 0. `out_kind`, `out_tag`, `out_data` and `out_pc` read 0.
- Reset applied mid-operation discards all queued entries, with no partial pop.
- Push-to-visibility latency is 1 cycle. An event sampled at edge N appears on `out_*` with `out_valid=1` after edge N, never combinationally in the same cycle. There is no bypass.
- Handshake: a transfer occurs at an edge where `out_valid && out_ready`. The head advances after that edge.
- While `out_valid && !out_ready`, `out_*` hold stable.
- `out_valid` is registered and derived from `level != 0`.
- Full FIFO with pop and one push in the same cycle: the push is accepted, `level` stays DEPTH, and no drop occurs.
- Empty FIFO with `out_ready=1` and no push: no change. `out_ready` is ignored while `!out_valid`.
- Sustained throughput is 1 pop/cycle. The burst input rate is 2 events/cycle.

## Configuration
- `TRACE_PC_EN` defined:
  - Each entry also stores `pc_out` sampled with the event; both events of a dual push carry the same PC.
  - `out_pc` port exists and follows the head entry.
- `TRACE_PC_EN` undefined:
  - `pc_out` is ignored and `out_pc` is absent.
  - Entry width is 66 bits instead of 98.

## Test plan
- Reset, then a single register write (rd=5, data 0xDEADBEEF) with `out_ready=0` -> next cycle `out_valid=1`, `out_kind=01`, `out_tag=0x00000005`, `out_data=0xDEADBEEF`, `level=1`; outputs stable until `out_ready=1`, then `level=0`.
- Register write with rd=0 plus memory write (addr 0x00000100, data 0x12345678) in the same cycle -> only the memory entry is queued: `out_kind=10`, `out_tag=0x00000100`.
- Register write (rd=3, 0x1) and memory write (0x200, 0x2) in the same cycle -> two entries, popped in order: register entry first, then memory entry.
- Fill 16 entries with `out_ready=0`, then a dual event -> both dropped, `drop_count=2`, `overflow=1`, `level=16`.
  - Next cycle: pop plus single push -> `level=16`, no new drop.
  - With 15 entries: a dual event stores the register event only, `drop_count` +1.
- Wrap-around: push/pop 40 sequential events (data = index) with random `out_ready` -> output sequence 0..39 in order, no loss, `overflow=0`.
- Assert reset low mid-stream with 7 entries queued -> `out_valid`, `level`, `drop_count` and `overflow` go 0 immediately, without a clock edge. With `TRACE_PC_EN`, an event at `pc_out=0x00000040` reports `out_pc=0x00000040`.

Source files
------------

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: captures retired register writes and memory writes from the
// RV32I core into a circular FIFO and presents them one per cycle on a valid/ready
// port. Up to two events are pushed per cycle; events that do not fit are dropped
// and counted, so the core is never stalled.
// Optional feature: define TRACE_PC_EN to store pc_out with each entry and expose out_pc.
module retire_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    register_write_en,
    input  logic [4:0]              rd_address,
    input  logic [31:0]             register_file_write,
    input  logic                    memory_write_en,
    input  logic [31:0]             memory_write_address,
    input  logic [31:0]             memory_write,
    input  logic [31:0]             pc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_kind,
    output logic [31:0]             out_tag,
    output logic [31:0]             out_data,
`ifdef TRACE_PC_EN
    output logic [31:0]             out_pc,
`endif
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef TRACE_PC_EN
    localparam int EW = 98;
`else
    localparam int EW = 66;
`endif

    // Entry layout: [65:64] kind, [63:32] tag, [31:0] data, [97:66] pc when enabled
    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              valid_q;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              reg_ev, mem_ev, pop;
    logic              reg_acc, mem_acc;
    logic [LW:0]       free_slots;
    logic [1:0]        n_acc, n_drop;
    logic [PW-1:0]     mem_slot;
    logic [DROP_W:0]   drop_sum;
    logic [EW-1:0]     reg_entry, mem_entry, head;

`ifdef TRACE_PC_EN
    assign reg_entry = {pc_out, 2'b01, 27'b0, rd_address, register_file_write};
    assign mem_entry = {pc_out, 2'b10, memory_write_address, memory_write};
`else
    logic unused_pc;
    assign unused_pc = ^pc_out;
    assign reg_entry = {2'b01, 27'b0, rd_address, register_file_write};
    assign mem_entry = {2'b10, memory_write_address, memory_write};
`endif

    // Admission: a same-cycle pop frees its slot; register event wins the last free slot
    always_comb begin
        reg_ev     = register_write_en && (rd_address != 5'd0);
        mem_ev     = memory_write_en;
        pop        = valid_q && out_ready;
        free_slots = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
        reg_acc    = reg_ev && (free_slots != '0);
        mem_acc    = mem_ev && (reg_acc ? (free_slots >= (LW+1)'(2)) : (free_slots != '0));
        n_acc      = {1'b0, reg_acc} + {1'b0, mem_acc};
        n_drop     = {1'b0, reg_ev && !reg_acc} + {1'b0, mem_ev && !mem_acc};
        mem_slot   = wr_ptr_q + PW'(reg_acc);
        wr_ptr_d   = wr_ptr_q + PW'(n_acc);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + LW'(n_acc) - LW'(pop);
        drop_sum   = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
        drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    // Storage array, cleared on reset so the head never reads X
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else begin
            if (reg_acc) mem_q[wr_ptr_q] <= reg_entry;
            if (mem_acc) mem_q[mem_slot] <= mem_entry;
        end
    end

    // Pointers, occupancy, registered valid and drop bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= (level_d != '0);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = valid_q;
    assign out_kind   = head[65:64];
    assign out_tag    = head[63:32];
    assign out_data   = head[31:0];
`ifdef TRACE_PC_EN
    assign out_pc     = head[97:66];
`endif
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: directed vector table, hand-written
// overflow/reset/wrap sequences, and randomized traffic against a queue model.
module tb_retire_trace_fifo;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              register_write_en;
    logic [4:0]        rd_address;
    logic [31:0]       register_file_write;
    logic              memory_write_en;
    logic [31:0]       memory_write_address;
    logic [31:0]       memory_write;
    logic [31:0]       pc_out;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [31:0]       out_tag;
    logic [31:0]       out_data;
`ifdef TRACE_PC_EN
    logic [31:0]       out_pc;
`endif
    logic [LW-1:0]     level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    always #5 clk = ~clk;

    retire_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_write_en    (register_write_en),
        .rd_address           (rd_address),
        .register_file_write  (register_file_write),
        .memory_write_en      (memory_write_en),
        .memory_write_address (memory_write_address),
        .memory_write         (memory_write),
        .pc_out               (pc_out),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_kind             (out_kind),
        .out_tag              (out_tag),
        .out_data             (out_data),
`ifdef TRACE_PC_EN
        .out_pc               (out_pc),
`endif
        .level                (level),
        .overflow             (overflow),
        .drop_count           (drop_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of trace entries plus drop bookkeeping
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] tag;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;
    ent_t        mq[$];
    int unsigned m_drop;
    bit          m_ovf;

    typedef struct {
        logic        rwe;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic        rdy;
        logic        e_valid;
        logic [1:0]  e_kind;
        logic [31:0] e_tag;
        logic [31:0] e_data;
        int          e_level;
    } vec_t;
    vec_t vt[9];

    function automatic vec_t mk(logic rwe, logic [4:0] rd, logic [31:0] rdata, logic mwe,
                                logic [31:0] maddr, logic [31:0] mdata, logic rdy, logic ev,
                                logic [1:0] ek, logic [31:0] et, logic [31:0] ed, int el);
        vec_t v;
        v.rwe = rwe; v.rd = rd; v.rdata = rdata; v.mwe = mwe; v.maddr = maddr;
        v.mdata = mdata; v.rdy = rdy; v.e_valid = ev; v.e_kind = ek; v.e_tag = et;
        v.e_data = ed; v.e_level = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rwe, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic mwe, input logic [31:0] maddr, input logic [31:0] mdata,
                         input logic rdy);
        register_write_en    = rwe;
        rd_address           = rd;
        register_file_write  = rdata;
        memory_write_en      = mwe;
        memory_write_address = maddr;
        memory_write         = mdata;
        out_ready            = rdy;
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Per-edge model: pop frees a slot first, then register event, then memory event
    task automatic model_step();
        int   free;
        ent_t e;
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        free = DEPTH - mq.size();
        if (register_write_en && rd_address != 5'd0) begin
            if (free > 0) begin
                e.kind = 2'b01; e.tag = {27'b0, rd_address}; e.data = register_file_write;
                e.pc = pc_out; mq.push_back(e); free--;
            end else begin
                m_drop++; m_ovf = 1'b1;
            end
        end
        if (memory_write_en) begin
            if (free > 0) begin
                e.kind = 2'b10; e.tag = memory_write_address; e.data = memory_write;
                e.pc = pc_out; mq.push_back(e); free--;
            end else begin
                m_drop++; m_ovf = 1'b1;
            end
        end
        if (m_drop > 65535) m_drop = 65535;
    endtask

    task automatic cmp_model(input string name);
        chk({name, ".valid"}, out_valid, mq.size() != 0);
        chk({name, ".level"}, level, mq.size());
        chk({name, ".ovf"}, overflow, m_ovf);
        chk({name, ".drop"}, drop_count, m_drop);
        if (mq.size() != 0) begin
            chk({name, ".kind"}, out_kind, mq[0].kind);
            chk({name, ".tag"}, out_tag, mq[0].tag);
            chk({name, ".data"}, out_data, mq[0].data);
`ifdef TRACE_PC_EN
            chk({name, ".pc"}, out_pc, mq[0].pc);
`endif
        end
    endtask

    task automatic step(input string name);
        model_step();
        @(posedge clk);
        #1;
        cmp_model(name);
    endtask

    logic [31:0] popped[$];

    initial begin
        int idx;
        int cyc;
        vt[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 2'b01, 32'h5, 32'hDEADBEEF, 1);
        vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 32'h5, 32'hDEADBEEF, 1);
        vt[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 0);
        vt[3] = mk(1, 0, 32'hFFFF, 1, 32'h100, 32'h12345678, 0, 1, 2'b10, 32'h100, 32'h12345678, 1);
        vt[4] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 0);
        vt[5] = mk(1, 3, 32'h1, 1, 32'h200, 32'h2, 0, 1, 2'b01, 32'h3, 32'h1, 2);
        vt[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 32'h200, 32'h2, 1);
        vt[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 0);
        vt[8] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        pc_out = 32'h0;
        reset  = 1'b0;
        #3;
        chk("rst.valid", out_valid, 0);
        chk("rst.level", level, 0);
        chk("rst.ovf", overflow, 0);
        chk("rst.drop", drop_count, 0);
        chk("rst.kind", out_kind, 0);
        chk("rst.tag", out_tag, 0);
        chk("rst.data", out_data, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].rwe, vt[i].rd, vt[i].rdata, vt[i].mwe, vt[i].maddr, vt[i].mdata, vt[i].rdy);
            step("vec");
            chk($sformatf("vec%0d.valid", i), out_valid, vt[i].e_valid);
            chk($sformatf("vec%0d.level", i), level, vt[i].e_level);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d.kind", i), out_kind, vt[i].e_kind);
                chk($sformatf("vec%0d.tag", i), out_tag, vt[i].e_tag);
                chk($sformatf("vec%0d.data", i), out_data, vt[i].e_data);
            end
        end

        // Fill to DEPTH, then overflow corner cases
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, i * 4, i, 0);
            step("fill");
        end
        chk("full.level", level, DEPTH);
        drive(1, 7, 32'hAA, 1, 32'h300, 32'hBB, 0);
        step("dualdrop");
        chk("dualdrop.level", level, DEPTH);
        chk("dualdrop.drop", drop_count, 2);
        chk("dualdrop.ovf", overflow, 1);
        chk("dualdrop.head", out_data, 0);
        drive(1, 9, 32'h99, 0, 0, 0, 1);
        step("poppush");
        chk("poppush.level", level, DEPTH);
        chk("poppush.drop", drop_count, 2);
        chk("poppush.head", out_data, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        step("pop1");
        chk("pop1.level", level, DEPTH - 1);
        drive(1, 11, 32'h77, 1, 32'h400, 32'h88, 0);
        step("dual15");
        chk("dual15.level", level, DEPTH);
        chk("dual15.drop", drop_count, 3);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            step("drain");
        end
        chk("drain.level", level, 7);

        // Asynchronous reset mid-stream with 7 entries queued
        #2;
        reset = 1'b0;
        #1;
        chk("arst.valid", out_valid, 0);
        chk("arst.level", level, 0);
        chk("arst.drop", drop_count, 0);
        chk("arst.ovf", overflow, 0);
        chk("arst.kind", out_kind, 0);
        chk("arst.tag", out_tag, 0);
        chk("arst.data", out_data, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifdef TRACE_PC_EN
        pc_out = 32'h40;
        drive(1, 4, 32'h1234, 0, 0, 0, 0);
        step("pc");
        chk("pc.out_pc", out_pc, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 1);
        step("pcdrain");
`endif

        // Wrap-around: 40 sequential events with random out_ready
        idx = 0;
        cyc = 0;
        popped.delete();
        while ((idx < 40 || mq.size() != 0) && cyc < 2000) begin
            if (idx < 40 && mq.size() < DEPTH - 1 && ($urandom % 2 == 1)) begin
                drive(0, 0, 0, 1, idx, idx, ($urandom % 4) != 0);
                idx++;
            end else begin
                drive(0, 0, 0, 0, 0, 0, ($urandom % 4) != 0);
            end
            pc_out = $urandom;
            if (out_valid && out_ready) popped.push_back(out_data);
            step("wrap");
            cyc++;
        end
        chk("wrap.timeout", cyc < 2000, 1);
        chk("wrap.count", popped.size(), 40);
        for (int i = 0; i < 40; i++) begin
            if (i < popped.size()) chk($sformatf("wrap.seq%0d", i), popped[i], i);
        end
        chk("wrap.ovf", overflow, 0);

        // Randomized traffic, first mostly stalled consumer then mostly ready
        for (int c = 0; c < 400; c++) begin
            drive($urandom % 2, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom % 2, $urandom, $urandom,
                  (c < 200) ? ($urandom % 4 == 0) : ($urandom % 4 != 0));
            pc_out = $urandom;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
